// File: rtl/mmio_write_arbiter.sv
// mmio_write_arbiter: round-robin arbiter for the shared peripheral write bus.
// Grants at most one valid requester per cycle and drives its write onto the
// bus through a single registered output stage.
//
// Optional build macro: MMIO_ADDR_FILTER_EN. When it is defined, writes outside
// [BASE_ADDR, BASE_ADDR+SPAN) are acknowledged but dropped. The first such
// write is recorded in err/err_addr/err_id.
//
// Ports:
//   clock, reset         rising-edge clock, async active-low reset
//   req_valid/addr/data  per-requester write request (slice i = requester i)
//   req_ready            one-hot combinational grant
//   bus_stall            downstream hold: no grants, bus outputs frozen
//   bus_we/addr/data     registered peripheral write bus
//   err/err_addr/err_id  sticky out-of-window capture (filter build only)
//   err_clear            clears the error capture
module mmio_write_arbiter #(
  parameter int unsigned                    DATA_WIDTH = 32,
  parameter int unsigned                    NUM_REQ    = 2,
  parameter logic [DATA_WIDTH-1:0]          BASE_ADDR  = 32'h9000_0000,
  parameter logic [DATA_WIDTH-1:0]          SPAN       = 32'h0000_1000,
  localparam int unsigned                   IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          bus_stall,
  output logic                          bus_we,
  output logic [DATA_WIDTH-1:0]         bus_addr,
  output logic [DATA_WIDTH-1:0]         bus_data,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         err_addr,
  output logic [IDW-1:0]                err_id,
  input  logic                          err_clear
);

  logic [IDW-1:0]        last_grant;
  logic [IDW-1:0]        grant_idx;
  logic                  grant_any;
  logic                  win_ok;
  int unsigned           cand;
  logic [DATA_WIDTH-1:0] addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  // Unpack the flat request buses into per-requester slices.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*DATA_WIDTH +: DATA_WIDTH];
    assign data_a[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_grant) + k) % NUM_REQ;
      if (!grant_any && !bus_stall && req_valid[IDW'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
  end

  assign req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  assign win_addr  = addr_a[grant_idx];
  assign win_data  = data_a[grant_idx];

`ifdef MMIO_ADDR_FILTER_EN
  // The window check is done in DATA_WIDTH+1 bits, so the top of the window cannot wrap.
  localparam logic [DATA_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [DATA_WIDTH:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, SPAN};

  logic reject;

  assign win_ok = ({1'b0, win_addr} >= WIN_LO) && ({1'b0, win_addr} < WIN_HI);
  assign reject = grant_any && !win_ok;

  // Sticky capture of the first rejected write. A new reject wins over err_clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err      <= 1'b0;
      err_addr <= '0;
      err_id   <= '0;
    end else if (reject && (!err || err_clear)) begin
      err      <= 1'b1;
      err_addr <= win_addr;
      err_id   <= grant_idx;
    end else if (err_clear) begin
      err      <= 1'b0;
      err_addr <= '0;
      err_id   <= '0;
    end
  end
`else
  logic unused_filter;

  assign win_ok        = 1'b1;
  assign err           = 1'b0;
  assign err_addr      = '0;
  assign err_id        = '0;
  assign unused_filter = ^{err_clear, BASE_ADDR, SPAN};
`endif

  // Output stage and grant pointer. A stall freezes everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_data   <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
    end else if (!bus_stall) begin
      if (grant_any) begin
        last_grant <= grant_idx;
        bus_addr   <= win_addr;
        bus_data   <= win_data;
        bus_we     <= win_ok;
      end else begin
        bus_we     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mmio_write_arbiter.sv
// Directed self-checking bench for mmio_write_arbiter (NUM_REQ=2, DATA_WIDTH=32).
module tb_mmio_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        bus_stall;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic        err;
  logic [31:0] err_addr;
  logic [0:0]  err_id;
  logic        err_clear;

  int checks = 0;
  int errors = 0;

  mmio_write_arbiter #(
    .DATA_WIDTH(32),
    .NUM_REQ(2),
    .BASE_ADDR(32'h9000_0000),
    .SPAN(32'h0000_1000)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .bus_stall(bus_stall),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_data(bus_data),
    .err(err), .err_addr(err_addr), .err_id(err_id), .err_clear(err_clear)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 2'b00; req_addr = '0; req_data = '0;
    bus_stall = 1'b0; err_clear = 1'b0;
    reset = 1'b0;
    step(); step();
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus_we); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus_addr); end
    checks++; if (bus_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus_data); end
    checks++; if ({err, err_addr, err_id} !== 34'h0) begin errors++; $display("FAIL reset_err got %b/%h/%b want 0", err, err_addr, err_id); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    req_valid = 2'b01; req_addr[31:0] = 32'h9000_0000; req_data[31:0] = 32'h0000_00A5;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    checks++; if ({bus_we, bus_addr, bus_data} !== {1'b1, 32'h9000_0000, 32'h0000_00A5})
      begin errors++; $display("FAIL single_write got %b %h %h want 1 90000000 000000a5", bus_we, bus_addr, bus_data); end
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_idle_ready got %b want 00", req_ready); end
    step();
    checks++; if ({bus_we, bus_addr} !== {1'b0, 32'h9000_0000}) begin errors++; $display("FAIL single_drop got %b %h want 0 90000000", bus_we, bus_addr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    apply_reset();
    req_addr = {32'h9000_0020, 32'h9000_0010};
    req_data = {32'h0000_0022, 32'h0000_0011};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_r = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (i % 2 == 0) ? 32'h11 : 32'h22;
      #1;
      checks++; if (req_ready !== exp_r) begin errors++; $display("FAIL b2b_ready[%0d] got %b want %b", i, req_ready, exp_r); end
      step();
      checks++; if ({bus_we, bus_data} !== {1'b1, exp_d}) begin errors++; $display("FAIL b2b_bus[%0d] got %b %h want 1 %h", i, bus_we, bus_data, exp_d); end
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_stall();
    // After test_back_to_back the last grant is requester 1, so requester 0 goes next.
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_pre_ready got %b want 01", req_ready); end
    step();
    bus_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d] got %b want 00", i, req_ready); end
      step();
      checks++; if ({bus_we, bus_addr, bus_data} !== {1'b1, 32'h9000_0010, 32'h11})
        begin errors++; $display("FAIL stall_frozen[%0d] got %b %h %h want 1 90000010 00000011", i, bus_we, bus_addr, bus_data); end
    end
    bus_stall = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_resume_ready got %b want 10", req_ready); end
    step();
    req_valid = 2'b00;
    checks++; if ({bus_we, bus_data} !== {1'b1, 32'h22}) begin errors++; $display("FAIL stall_resume_bus got %b %h want 1 00000022", bus_we, bus_data); end
    step();
  endtask

  task automatic req1_write(input logic [31:0] a, input logic [31:0] d);
    req_valid = 2'b10; req_addr[63:32] = a; req_data[63:32] = d;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL filt_ready(%h) got %b want 10", a, req_ready); end
    step();
    req_valid = 2'b00;
  endtask

  task automatic test_filter();
`ifdef MMIO_ADDR_FILTER_EN
    req1_write(32'h8000_0000, 32'h33);
    checks++; if ({bus_we, err, err_addr, err_id} !== {1'b0, 1'b1, 32'h8000_0000, 1'b1})
      begin errors++; $display("FAIL filt_low got we=%b err=%b %h id=%b want 0 1 80000000 1", bus_we, err, err_addr, err_id); end
    req1_write(32'h9000_1000, 32'h34);
    checks++; if ({bus_we, err, err_addr} !== {1'b0, 1'b1, 32'h8000_0000})
      begin errors++; $display("FAIL filt_high got we=%b err=%b %h want 0 1 80000000", bus_we, err, err_addr); end
    req1_write(32'h9000_0FFF, 32'h35);
    checks++; if ({bus_we, bus_addr, err_addr} !== {1'b1, 32'h9000_0FFF, 32'h8000_0000})
      begin errors++; $display("FAIL filt_top_in got we=%b %h erra=%h want 1 90000fff 80000000", bus_we, bus_addr, err_addr); end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++; if ({err, err_addr} !== {1'b0, 32'h0}) begin errors++; $display("FAIL filt_clear got %b %h want 0 0", err, err_addr); end
    req1_write(32'h8000_0008, 32'h36);
    err_clear = 1'b1;
    req1_write(32'h8000_000C, 32'h37);
    err_clear = 1'b0;
    checks++; if ({err, err_addr} !== {1'b1, 32'h8000_000C}) begin errors++; $display("FAIL filt_clear_race got %b %h want 1 8000000c", err, err_addr); end
`else
    req1_write(32'h8000_0000, 32'h44);
    checks++; if ({bus_we, bus_addr, bus_data} !== {1'b1, 32'h8000_0000, 32'h44})
      begin errors++; $display("FAIL nofilt_fwd got %b %h %h want 1 80000000 00000044", bus_we, bus_addr, bus_data); end
    checks++; if ({err, err_addr, err_id} !== 34'h0) begin errors++; $display("FAIL nofilt_err got %b %h %b want 0", err, err_addr, err_id); end
`endif
    step();
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; req_addr[31:0] = 32'h9000_0040; req_data[31:0] = 32'h55;
    step();
    checks++; if (bus_we !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b want 1", bus_we); end
    reset = 1'b0;
    #1;
    checks++; if ({bus_we, bus_addr, bus_data} !== 65'h0) begin errors++; $display("FAIL rst_mid_async got %b %h %h want 0", bus_we, bus_addr, bus_data); end
    #2;
    reset = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_mid_first got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    checks++; if ({bus_we, bus_data} !== {1'b1, 32'h55}) begin errors++; $display("FAIL rst_mid_write got %b %h want 1 00000055", bus_we, bus_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_filter();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
